uart_frame_loader: RTL and testbench
====================================

# uart_frame_loader

Receive-side framing stage between the UART `Receiver` byte output and the shared matrix `Memory` write port. Hunts for a start-of-frame byte, then a matrix-select byte, then a row-major payload of `DIM*DIM` bytes. Each payload byte becomes one memory write. When both operand matrices (select 0 and 1) have loaded cleanly, it pulses `mac_start` to launch the matrix controllers.

## Interface
- `DIM`, 8: matrix dimension (rows = cols); legal 1..16
- `SOF`, 8'hA5: start-of-frame byte
- `TIMEOUT_CYC`, 200000: max `clk` cycles between accepted bytes inside a frame

Ports:
- `clk`  in  1  system clock (sole clock)
- `reset`  in  1  synchronous, active-high
- `rhr_data`  in  8  received byte; stable while `data_ready` high
- `data_ready`  in  1  level from `Receiver`; rising edge = new byte
- `write_enable`  out  1  memory write strobe, one cycle per payload byte
- `matrix_select`  out  2  target matrix (0 or 1)
- `row`  out  4  write row
- `col`  out  4  write column
- `write_data`  out  8  write byte
- `busy`  out  1  high in any state other than IDLE
- `frame_done`  out  1  one-cycle pulse, frame accepted
- `frame_err`  out  1  one-cycle pulse, frame rejected
- `mac_start`  out  1  one-cycle pulse, both operands loaded

## Operation
- Byte accept: `rdy_q` registers `data_ready`. A byte is accepted in the cycle where `data_ready & ~rdy_q`. Bytes are ignored while `data_ready` is held high.
- States:
  - IDLE → SEL on accepted byte == `SOF`; other bytes are discarded.
  - SEL: accepted byte[1:0] ∈ {0,1} latches `matrix_select` and clears the row/col counters, then → DATA. Any other value, or byte[7:2] ≠ 0, pulses `frame_err` → IDLE.
  - DATA: each accepted byte issues a write at the current row/col. Column increments; at `DIM-1` it wraps to 0 and row increments. After the write at (`DIM-1`,`DIM-1`) → CSUM if `FRAME_CSUM_EN`, else → FIN.
  - CSUM: accepted byte compared to the running XOR → FIN on match, else `frame_err` → IDLE.
  - FIN: one cycle. Pulses `frame_done`, sets `loaded[matrix_select]` → IDLE.
- The running XOR is cleared in IDLE and covers the select byte plus all payload bytes.
- `loaded[1:0]`: when both bits are set, `mac_start` pulses and both bits clear in the same cycle.
- A rejected frame does not set `loaded`. Memory bytes already written are not rolled back.
- Timeout: a counter resets on every accepted byte and runs in SEL/DATA/CSUM. Reaching `TIMEOUT_CYC` pulses `frame_err` → IDLE.
- `SOF` appearing inside a payload is treated as data; there is no resynchronisation.

## Timing
- Reset values: `write_enable`, `busy`, `frame_done`, `frame_err`, `mac_start` = 0. `matrix_select`, `row`, `col`, `write_data` = 0. `loaded` = 0, state IDLE.
- `reset` asserted mid-frame: next edge forces IDLE and all of the above values. The partial frame is abandoned.
- Payload byte accepted in cycle N → `write_enable`=1 in cycle N+1 with `row`/`col`/`write_data` valid; the address advances at N+2.
- Final byte (payload, or checksum if enabled) accepted at N → `frame_done` at N+2 → `mac_start` at N+3 if the other bit of `loaded` is already set.
- Timeout and a byte accept in the same cycle: the accept wins.
- Max throughput: one byte per 2 cycles.

## Configuration
- `FRAME_CSUM_EN` defined: a checksum byte follows the payload. Frame length = `DIM*DIM`+3 bytes. A mismatch gives `frame_err`.
- Undefined: no CSUM state and no XOR logic. Frame length = `DIM*DIM`+2 bytes. FIN follows the last payload byte directly.

## Test plan
- Send `A5 00` plus 64 bytes 0x01..0x40 (+ csum 0x40 if enabled) → 64 writes, last at row 7/col 7 data 0x40; `frame_done` once; `mac_start` = 0.
- Matrix 0 frame then matrix 1 frame → single `mac_start` pulse 3 cycles after the final byte accept; `loaded` returns to 0.
- `FRAME_CSUM_EN`: matrix-0 frame with checksum 0x00 instead of the correct 0x40 → `frame_err`, no `frame_done`; a following good matrix-1 frame yields no `mac_start`.
- Bytes `33 A5 02` → first byte ignored, then `frame_err` on the select byte, `busy` low afterwards, zero writes.
- `A5 01` plus 10 payload bytes, then silence for `TIMEOUT_CYC` cycles → 10 writes, `frame_err` at the timeout, then IDLE; `reset` pulsed mid-frame in a second run → all outputs 0 the next cycle.

Source files
------------

// File: rtl/uart_frame_loader.sv
// rtl/uart_frame_loader.sv - UART byte framer feeding matrix memory writes; optional checksum via FRAME_CSUM_EN
module uart_frame_loader #(
  parameter int unsigned DIM         = 8,
  parameter logic [7:0]  SOF         = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rhr_data,
  input  logic       data_ready,
  output logic       write_enable,
  output logic [1:0] matrix_select,
  output logic [3:0] row,
  output logic [3:0] col,
  output logic [7:0] write_data,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_err,
  output logic       mac_start
);

  localparam int unsigned TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [3:0]  LAST_IDX = 4'(DIM - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

`ifdef FRAME_CSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_SEL, S_DATA, S_CSUM, S_FIN} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_SEL, S_DATA, S_FIN} state_t;
`endif

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_rdy_q;
  logic            w_accept;
  logic            w_timeout;
  logic            w_sel_ok;
  logic            w_last_pos;
  logic            w_we_nxt;
  logic            w_done_nxt;
  logic            w_err_nxt;
  logic            w_sel_load;
  logic [TW-1:0]   r_to_cnt;
  logic            r_we;
  logic            r_done;
  logic            r_err;
  logic            r_mac;
  logic [1:0]      r_sel;
  logic [1:0]      r_loaded;
  logic [3:0]      r_row;
  logic [3:0]      r_col;
  logic [7:0]      r_wdata;
`ifdef FRAME_CSUM_EN
  logic [7:0]      r_csum;
`endif

  // A new byte is the rising edge of the receiver's ready level.
  assign w_accept   = data_ready & ~r_rdy_q;
  assign w_timeout  = (r_to_cnt == TO_LAST);
  assign w_sel_ok   = (rhr_data[7:1] == 7'd0);
  assign w_last_pos = (r_row == LAST_IDX) && (r_col == LAST_IDX);

  // Edge detector for data_ready.
  always_ff @(posedge clk) begin
    if (reset) r_rdy_q <= 1'b0;
    else       r_rdy_q <= data_ready;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and strobe decode; an accepted byte takes priority over the timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_we_nxt    = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_sel_load  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && (rhr_data == SOF)) w_state_nxt = S_SEL;
      end
      S_SEL: begin
        if (w_accept) begin
          if (w_sel_ok) begin
            w_sel_load  = 1'b1;
            w_state_nxt = S_DATA;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else if (w_timeout) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_DATA: begin
        if (w_accept) begin
          w_we_nxt = 1'b1;
`ifdef FRAME_CSUM_EN
          if (w_last_pos) w_state_nxt = S_CSUM;
`else
          if (w_last_pos) w_state_nxt = S_FIN;
`endif
        end else if (w_timeout) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
`ifdef FRAME_CSUM_EN
      S_CSUM: begin
        if (w_accept) begin
          if (rhr_data == r_csum) begin
            w_state_nxt = S_FIN;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else if (w_timeout) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
`endif
      S_FIN: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Inter-byte timeout counter, only running while a frame is open.
  always_ff @(posedge clk) begin
    if (reset || w_accept || (r_state == S_IDLE) || (r_state == S_FIN)) r_to_cnt <= '0;
    else                                                                 r_to_cnt <= r_to_cnt + 1'b1;
  end

`ifdef FRAME_CSUM_EN
  // Running XOR over the select byte and every payload byte.
  always_ff @(posedge clk) begin
    if (reset || (r_state == S_IDLE)) begin
      r_csum <= 8'd0;
    end else if (w_accept && ((r_state == S_SEL) || (r_state == S_DATA))) begin
      r_csum <= r_csum ^ rhr_data;
    end
  end
`endif

  // Write port: strobe and data one cycle after accept, address advances the cycle after the strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_wdata <= 8'd0;
      r_sel   <= 2'd0;
      r_row   <= 4'd0;
      r_col   <= 4'd0;
    end else begin
      r_we <= w_we_nxt;
      if (w_we_nxt) r_wdata <= rhr_data;
      if (w_sel_load) begin
        r_sel <= {1'b0, rhr_data[0]};
        r_row <= 4'd0;
        r_col <= 4'd0;
      end else if (r_we) begin
        if (r_col == LAST_IDX) begin
          r_col <= 4'd0;
          r_row <= (r_row == LAST_IDX) ? 4'd0 : r_row + 4'd1;
        end else begin
          r_col <= r_col + 4'd1;
        end
      end
    end
  end

  // Frame status pulses and operand-loaded tracking that launches the MAC.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_mac    <= 1'b0;
      r_loaded <= 2'b00;
    end else begin
      r_done <= w_done_nxt;
      r_err  <= w_err_nxt;
      if (r_loaded == 2'b11) begin
        r_mac    <= 1'b1;
        r_loaded <= 2'b00;
      end else begin
        r_mac <= 1'b0;
        if (w_done_nxt) r_loaded[r_sel[0]] <= 1'b1;
      end
    end
  end

  assign write_enable  = r_we;
  assign write_data    = r_wdata;
  assign matrix_select = r_sel;
  assign row           = r_row;
  assign col           = r_col;
  assign busy          = (r_state != S_IDLE);
  assign frame_done    = r_done;
  assign frame_err     = r_err;
  assign mac_start     = r_mac;

endmodule

// File: tb/tb_uart_frame_loader.sv
// tb/tb_uart_frame_loader.sv - directed bench for uart_frame_loader
module tb_uart_frame_loader;

  localparam int TO = 300;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rhr_data = 8'd0;
  logic       data_ready = 1'b0;
  logic       write_enable;
  logic [1:0] matrix_select;
  logic [3:0] row;
  logic [3:0] col;
  logic [7:0] write_data;
  logic       busy;
  logic       frame_done;
  logic       frame_err;
  logic       mac_start;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int mac_cnt = 0;
  int done_cyc = -1;
  int err_cyc = -1;
  int mac_cyc = -1;
  int last_acc = 0;
  logic [7:0] last_csum;
  logic [3:0] wr_row [1024];
  logic [3:0] wr_col [1024];
  logic [7:0] wr_data [1024];

  uart_frame_loader #(.DIM(8), .SOF(8'hA5), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .rhr_data(rhr_data), .data_ready(data_ready),
    .write_enable(write_enable), .matrix_select(matrix_select), .row(row), .col(col),
    .write_data(write_data), .busy(busy), .frame_done(frame_done), .frame_err(frame_err),
    .mac_start(mac_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (write_enable) begin
      if (wr_cnt < 1024) begin
        wr_row[wr_cnt]  = row;
        wr_col[wr_cnt]  = col;
        wr_data[wr_cnt] = write_data;
      end
      wr_cnt = wr_cnt + 1;
    end
    if (frame_done) begin done_cnt = done_cnt + 1; done_cyc = cyc; end
    if (frame_err)  begin err_cnt = err_cnt + 1;   err_cyc = cyc;  end
    if (mac_start)  begin mac_cnt = mac_cnt + 1;   mac_cyc = cyc;  end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rhr_data = b;
    data_ready = 1'b1;
    @(posedge clk); #1;
    data_ready = 1'b0;
    last_acc = cyc;
  endtask

  task automatic send_frame(input logic [7:0] sel, input logic [7:0] first, input bit incr,
                            input logic [7:0] csum);
    logic [7:0] d;
    send_byte(8'hA5);
    send_byte(sel);
    d = first;
    for (int i = 0; i < 64; i++) begin
      send_byte(d);
      if (incr) d = d + 8'd1;
    end
`ifdef FRAME_CSUM_EN
    send_byte(csum);
`else
    last_csum = csum;
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({write_enable, busy, frame_done, frame_err, mac_start} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b expected 00000",
               {write_enable, busy, frame_done, frame_err, mac_start});
    end
    n_tests++;
    if ({matrix_select, row, col, write_data} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_addr: got sel=%0d row=%0d col=%0d data=%h expected all 0",
               matrix_select, row, col, write_data);
    end
    #1 reset = 1'b0;
  endtask

  task automatic test_frame0;
    int w0, d0, e0, m0, bad, first_bad;
    w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt; m0 = mac_cnt;
    send_frame(8'h00, 8'h01, 1'b1, 8'h40);
    idle(4);
    n_tests++;
    if (wr_cnt - w0 !== 64) begin
      n_fail++; $display("FAIL frame0_writes: got %0d expected 64", wr_cnt - w0);
    end
    n_tests++;
    if ({wr_row[w0 + 63], wr_col[w0 + 63], wr_data[w0 + 63]} !== {4'd7, 4'd7, 8'h40}) begin
      n_fail++;
      $display("FAIL frame0_last: got row=%0d col=%0d data=%h expected row=7 col=7 data=40",
               wr_row[w0 + 63], wr_col[w0 + 63], wr_data[w0 + 63]);
    end
    bad = 0; first_bad = -1;
    for (int i = 0; i < 64; i++) begin
      if ({wr_row[w0 + i], wr_col[w0 + i], wr_data[w0 + i]} !== {4'(i / 8), 4'(i % 8), 8'(i + 1)}) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL frame0_order: got %0d bad writes (first %0d) expected 0", bad, first_bad);
    end
    n_tests++;
    if (done_cnt - d0 !== 1) begin
      n_fail++; $display("FAIL frame0_done: got %0d expected 1", done_cnt - d0);
    end
    n_tests++;
    if ((mac_cnt - m0 !== 0) || (err_cnt - e0 !== 0)) begin
      n_fail++; $display("FAIL frame0_mac_err: got mac=%0d err=%0d expected 0 0", mac_cnt - m0, err_cnt - e0);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL frame0_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_back_to_back;
    int m0, d0;
    m0 = mac_cnt;
    send_frame(8'h01, 8'h01, 1'b1, 8'h41);
    idle(4);
    n_tests++;
    if (mac_cnt - m0 !== 1) begin
      n_fail++; $display("FAIL mac_pulse: got %0d expected 1", mac_cnt - m0);
    end
    n_tests++;
    if ((done_cyc !== last_acc + 1) || (mac_cyc !== last_acc + 2)) begin
      n_fail++;
      $display("FAIL mac_timing: got done=%0d mac=%0d expected done=%0d mac=%0d",
               done_cyc, mac_cyc, last_acc + 1, last_acc + 2);
    end
    n_tests++;
    if (matrix_select !== 2'd1) begin
      n_fail++; $display("FAIL sel1: got %0d expected 1", matrix_select);
    end
    m0 = mac_cnt; d0 = done_cnt;
    send_frame(8'h01, 8'h01, 1'b1, 8'h41);
    idle(4);
    n_tests++;
    if ((mac_cnt - m0 !== 0) || (done_cnt - d0 !== 1)) begin
      n_fail++;
      $display("FAIL loaded_cleared: got mac=%0d done=%0d expected mac=0 done=1", mac_cnt - m0, done_cnt - d0);
    end
  endtask

  task automatic test_sof_in_payload;
    int w0, d0, bad;
    w0 = wr_cnt; d0 = done_cnt;
    send_frame(8'h01, 8'hA5, 1'b0, 8'h01);
    idle(4);
    bad = 0;
    for (int i = 0; i < 64; i++) if (wr_data[w0 + i] !== 8'hA5) bad++;
    n_tests++;
    if ((wr_cnt - w0 !== 64) || (bad !== 0) || (done_cnt - d0 !== 1)) begin
      n_fail++;
      $display("FAIL sof_payload: got writes=%0d bad=%0d done=%0d expected 64 0 1", wr_cnt - w0, bad, done_cnt - d0);
    end
  endtask

`ifdef FRAME_CSUM_EN
  task automatic test_csum_err;
    int d0, e0, m0;
    d0 = done_cnt; e0 = err_cnt; m0 = mac_cnt;
    send_frame(8'h00, 8'h01, 1'b1, 8'h00);
    idle(4);
    n_tests++;
    if ((err_cnt - e0 !== 1) || (done_cnt - d0 !== 0)) begin
      n_fail++; $display("FAIL csum_bad: got err=%0d done=%0d expected 1 0", err_cnt - e0, done_cnt - d0);
    end
    send_frame(8'h01, 8'h01, 1'b1, 8'h41);
    idle(4);
    n_tests++;
    if ((mac_cnt - m0 !== 0) || (done_cnt - d0 !== 1)) begin
      n_fail++; $display("FAIL csum_nomac: got mac=%0d done=%0d expected 0 1", mac_cnt - m0, done_cnt - d0);
    end
  endtask
`endif

  task automatic test_bad_sel;
    int w0, e0, d0;
    w0 = wr_cnt; e0 = err_cnt; d0 = done_cnt;
    send_byte(8'h33);
    idle(1);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL badsel_ignore: got busy=%b expected 0", busy);
    end
    send_byte(8'hA5);
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL badsel_sof: got busy=%b expected 1", busy);
    end
    send_byte(8'h02);
    idle(3);
    n_tests++;
    if ((err_cnt - e0 !== 1) || (busy !== 1'b0) || (wr_cnt - w0 !== 0) || (done_cnt - d0 !== 0)) begin
      n_fail++;
      $display("FAIL badsel: got err=%0d busy=%b writes=%0d done=%0d expected 1 0 0 0",
               err_cnt - e0, busy, wr_cnt - w0, done_cnt - d0);
    end
  endtask

  task automatic test_timeout;
    int w0, e0, d0;
    w0 = wr_cnt; e0 = err_cnt; d0 = done_cnt;
    send_byte(8'hA5);
    send_byte(8'h01);
    for (int i = 0; i < 10; i++) send_byte(8'(8'h10 + i));
    for (int i = 0; i < TO + 50 && err_cnt == e0; i++) @(negedge clk);
    n_tests++;
    if (err_cnt - e0 !== 1) begin
      n_fail++; $display("FAIL timeout_err: got %0d pulses expected 1 within %0d cycles", err_cnt - e0, TO + 50);
    end
    n_tests++;
    if (err_cyc !== last_acc + TO) begin
      n_fail++; $display("FAIL timeout_cycle: got %0d expected %0d", err_cyc, last_acc + TO);
    end
    idle(2);
    n_tests++;
    if ((wr_cnt - w0 !== 10) || (busy !== 1'b0) || (done_cnt - d0 !== 0)) begin
      n_fail++;
      $display("FAIL timeout_state: got writes=%0d busy=%b done=%0d expected 10 0 0", wr_cnt - w0, busy, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid;
    int m0, d0;
    send_byte(8'hA5);
    send_byte(8'h01);
    for (int i = 0; i < 5; i++) send_byte(8'(8'h01 + i));
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({write_enable, busy, frame_done, frame_err, mac_start, matrix_select, row, col, write_data} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got we=%b busy=%b sel=%0d row=%0d col=%0d data=%h expected all 0",
               write_enable, busy, matrix_select, row, col, write_data);
    end
    #1 reset = 1'b0;
    idle(2);
    m0 = mac_cnt; d0 = done_cnt;
    send_frame(8'h00, 8'h01, 1'b1, 8'h40);
    idle(4);
    n_tests++;
    if ((mac_cnt - m0 !== 0) || (done_cnt - d0 !== 1)) begin
      n_fail++;
      $display("FAIL reset_loaded: got mac=%0d done=%0d expected 0 1", mac_cnt - m0, done_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_frame0();
    test_back_to_back();
    test_sof_in_payload();
`ifdef FRAME_CSUM_EN
    test_csum_err();
`endif
    test_bad_sel();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
